filter_ctrl: RTL and testbench

//  Sequencer for the 24-bit tapped-delay-line filter datapath (shift_24 delay line + shared MAC).
//  - Accepts one sample per ready/valid handshake and pulses the delay-line shift enable.
//  - Steps one shared multiply-accumulate unit through every tap.
//  - Suppresses results until the window is full, then presents the result downstream under backpressure.
//  - Sits inside filter, between the stream ports and the datapath. Produces control only; carries no data.

---
 rtl/filter_pkg.sv | 29 ++
 rtl/filter_tap_counter.sv | 43 ++++
 rtl/filter_ctrl.sv | 119 +++++++++++
 tb/tb_filter_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and sizing for the tapped-delay-line filter.
// Tap-index and fill widths are common to the sequencer and the MAC datapath.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    HOLD
  } state_e;

  localparam int unsigned DEPTH_DEF = 7;
  localparam int unsigned WIDTH_DEF = 24;

  function automatic int unsigned tap_w(
    input int unsigned d
  );
    return (d < 2) ? 1 : $clog2(d);
  endfunction

  function automatic int unsigned fill_w(
    input int unsigned d
  );
    return $clog2(d + 1);
  endfunction

  localparam int unsigned TAP_W  = tap_w(DEPTH_DEF);
  localparam int unsigned FILL_W = fill_w(DEPTH_DEF);

endpackage

// File: rtl/filter_tap_counter.sv
// Tap index counter: clear, enable, wrap at limit_p-1.
// last_o flags the final tap of a MAC pass.
module filter_tap_counter
  import filter_pkg::*;
#(
  parameter int unsigned limit_p = DEPTH_DEF,
  parameter int unsigned width_p = TAP_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [width_p-1:0] tap_o,
  output logic               last_o
);

  localparam logic [width_p-1:0] LAST =
    width_p'(limit_p - 1);

  logic [width_p-1:0] tap_q;
  logic [width_p-1:0] tap_d;

  assign last_o = (tap_q == LAST);
  assign tap_o  = tap_q;

  always_comb begin
    tap_d = tap_q;
    if (clr_i) begin
      tap_d = '0;
    end else if (en_i) begin
      tap_d = last_o ? '0 : tap_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// Sequencer for the tapped-delay-line filter: sample handshake,
// MAC tap stepping, warmup suppression and result backpressure.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned depth_p  = DEPTH_DEF,
  parameter bit          warmup_p = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  input  logic                          flush_i,
  output logic                          shift_en_o,
  output logic [tap_w(depth_p)-1:0]     tap_sel_o,
  output logic                          acc_clr_o,
  output logic                          acc_en_o,
  output logic [fill_w(depth_p)-1:0]    fill_o
);

  localparam int unsigned TW = tap_w(depth_p);
  localparam int unsigned FW = fill_w(depth_p);
  localparam logic [FW-1:0] FULL = FW'(depth_p);

  state_e          state_q;
  state_e          state_d;
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_d;
  logic [TW-1:0]   tap;
  logic            tap_last;
  logic            take;

  filter_tap_counter #(
    .limit_p (depth_p),
    .width_p (TW)
  ) u_tap (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (flush_i),
    .en_i    (state_q == MAC),
    .tap_o   (tap),
    .last_o  (tap_last)
  );

  // HOLD with ready_i and valid_i accepts the next sample without a bubble
  assign take = valid_i & ~flush_i &
                ((state_q == IDLE) |
                 ((state_q == HOLD) & ready_i));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (flush_i) begin
      state_d = IDLE;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (valid_i) state_d = MAC;
        MAC: begin
          if (tap_last) begin
            state_d = (!warmup_p || fill_q == FULL)
                      ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (ready_i) state_d = valid_i ? MAC : IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (take && fill_q != FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    shift_en_o = 1'b0;
    acc_clr_o  = 1'b0;
    acc_en_o   = 1'b0;
    tap_sel_o  = '0;
    if (reset_i) begin
      unique case (state_q)
        IDLE: begin
          ready_o    = ~flush_i;
          shift_en_o = take;
          acc_clr_o  = take;
        end
        MAC: begin
          acc_en_o  = 1'b1;
          tap_sel_o = tap;
        end
        HOLD: begin
          valid_o    = ~flush_i;
          ready_o    = ready_i & ~flush_i;
          shift_en_o = take;
          acc_clr_o  = take;
        end
        default: ;
      endcase
    end
  end

  assign fill_o = fill_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Scoreboard bench for filter_ctrl (depth_p=7, warmup_p=1).
// Driver queues expected result timing; a monitor checks each result.
module tb_filter_ctrl;

  localparam int DEPTH = 7;

  logic       clk_i;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic       valid_o;
  logic       ready_i;
  logic       flush_i;
  logic       shift_en_o;
  logic [2:0] tap_sel_o;
  logic       acc_clr_o;
  logic       acc_en_o;
  logic [2:0] fill_o;

  typedef struct {
    int cyc;
    int fill;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_tap = 0;
  bit   prev_stall = 0;

  filter_ctrl #(
    .depth_p  (DEPTH),
    .warmup_p (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .flush_i    (flush_i),
    .shift_en_o (shift_en_o),
    .tap_sel_o  (tap_sel_o),
    .acc_clr_o  (acc_clr_o),
    .acc_en_o   (acc_en_o),
    .fill_o     (fill_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int outs();
    return {ready_o, valid_o, shift_en_o,
            acc_clr_o, acc_en_o, tap_sel_o, fill_o};
  endfunction

  // Monitor: tap sequence and result timing
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (acc_en_o) begin
        chk("tap_seq", int'(tap_sel_o), exp_tap);
        exp_tap = (exp_tap == DEPTH-1) ? 0 : exp_tap + 1;
      end
      if (valid_o && !prev_stall) begin
        if (sbq.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("fill_at_result", int'(fill_o), e.fill);
        end
      end
      prev_stall = valid_o && !ready_i;
      if (flush_i) begin
        exp_tap    = 0;
        prev_stall = 0;
      end
    end else begin
      exp_tap    = 0;
      prev_stall = 0;
    end
  end

  task automatic send(input bit exp_res,
                      output bit in_hold);
    int n = 0;
    valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    in_hold = 1'b0;
    if (!ready_o) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      chk("shift_en", int'(shift_en_o), 1);
      chk("acc_clr", int'(acc_clr_o), 1);
      in_hold = valid_o;
      if (exp_res) sbq.push_back('{cyc + DEPTH + 1, DEPTH});
    end
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_tap(input int t);
    int n = 0;
    @(negedge clk_i);
    while (!(acc_en_o && int'(tap_sel_o) == t) && n < 30) begin
      n++;
      @(negedge clk_i);
    end
    chk("wait_tap", int'(tap_sel_o), t);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("drain", sbq.size(), 0);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    int n;
    reset_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset_outs", outs(), 0);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_fill", int'(fill_o), 0);

    // 1: async reset mid-MAC at tap 3
    @(posedge clk_i);
    #1;
    send(1'b0, h);
    wait_tap(3);
    #1 reset_i = 1'b0;
    #1 chk("midmac_reset_outs", outs(), 0);
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(negedge clk_i);
    chk("rel_ready", int'(ready_o), 1);
    chk("rel_fill", int'(fill_o), 0);
    @(posedge clk_i);
    #1;

    // 2: warmup, samples 10..16
    for (int i = 0; i < 7; i++) begin
      send(i == 6, h);
      chk("warm_no_hold", int'(h), 0);
    end
    drain();
    chk("warm_fill", int'(fill_o), 7);

    // 3: backpressure in HOLD
    ready_i = 1'b0;
    send(1'b1, h);
    n = 0;
    @(negedge clk_i);
    while (!valid_o && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_i);
      chk("bp_valid", int'(valid_o), 1);
      chk("bp_acc_en", int'(acc_en_o), 0);
      chk("bp_ready", int'(ready_o), 0);
    end
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_valid", int'(valid_o), 1);
    @(negedge clk_i);
    chk("bp_idle_ready", int'(ready_o), 1);
    chk("bp_idle_valid", int'(valid_o), 0);
    @(posedge clk_i);
    #1;

    // 4: overlap accept in HOLD
    send(1'b1, h);
    chk("ovl_first_hold", int'(h), 0);
    send(1'b1, h);
    chk("ovl_in_hold", int'(h), 1);
    @(negedge clk_i);
    chk("ovl_mac", int'(acc_en_o), 1);
    chk("ovl_tap0", int'(tap_sel_o), 0);
    drain();

    // 5: flush at MAC tap 2
    send(1'b1, h);
    wait_tap(1);
    @(posedge clk_i);
    #1 flush_i = 1'b1;
    sbq.delete();
    @(negedge clk_i);
    chk("fl_tap", int'(tap_sel_o), 2);
    chk("fl_ready", int'(ready_o), 0);
    chk("fl_valid", int'(valid_o), 0);
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("fl_idle_ready", int'(ready_o), 1);
    chk("fl_fill", int'(fill_o), 0);
    chk("fl_no_valid", int'(valid_o), 0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) send(1'b0, h);
    repeat (12) @(negedge clk_i);
    chk("fl_fill6", int'(fill_o), 6);

    // 6: saturation over 20 streamed samples
    @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("sat_start_fill", int'(fill_o), 0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 20; i++) begin
      send(i >= 6, h);
      chk("sat_overlap", int'(h), int'(i >= 7));
    end
    drain();
    chk("sat_fill", int'(fill_o), 7);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
